// File: rtl/pam_tx_channel_model_if.sv
// Symbol input and differential level outputs of the PAM driver + channel model.
interface pam_tx_channel_model_if #(
    parameter int unsigned SYM_BITWIDTH = 1,
    parameter int unsigned DATA_WIDTH   = 16
) ();
    logic [SYM_BITWIDTH-1:0]      sym_in;
    logic                         sym_valid;
    logic signed [DATA_WIDTH-1:0] tx_p;
    logic signed [DATA_WIDTH-1:0] tx_n;
    logic signed [DATA_WIDTH-1:0] ch_p;
    logic signed [DATA_WIDTH-1:0] ch_n;
    logic signed [DATA_WIDTH-1:0] ch_diff;

    modport master (
        output sym_in, sym_valid,
        input  tx_p, tx_n, ch_p, ch_n, ch_diff
    );

    modport slave (
        input  sym_in, sym_valid,
        output tx_p, tx_n, ch_p, ch_n, ch_diff
    );
endinterface

// File: rtl/pam_tx_channel_model.sv
// PAM transmit driver feeding a first-order IIR low-pass per leg; one clock per UI.
module pam_tx_channel_model #(
    parameter int unsigned SYM_BITWIDTH = 1,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int          AMP          = 1000,
    parameter int          VCM          = 0,
    parameter int unsigned ALPHA        = 64,
    parameter int unsigned ALPHA_FRAC   = 8
) (
    input  logic clk,
    input  logic rstb,
    pam_tx_channel_model_if.slave bus_if
);
    localparam int unsigned M  = 1 << SYM_BITWIDTH;
    localparam int unsigned PW = DATA_WIDTH + ALPHA_FRAC + 2;

    localparam logic signed [PW-1:0]         LMAX_W  = PW'(M - 1);
    localparam logic signed [PW-1:0]         AMP_W   = PW'(AMP);
    localparam logic signed [PW-1:0]         VCM_W   = PW'(VCM);
    localparam logic signed [PW-1:0]         ALPHA_W = PW'(ALPHA);
    localparam logic signed [DATA_WIDTH-1:0] VCM_D   = DATA_WIDTH'(VCM);

    localparam longint LIMIT   = longint'(1) <<< (DATA_WIDTH - 1);
    localparam longint ABS_VCM = (VCM < 0) ? -longint'(VCM) : longint'(VCM);
    localparam longint PEAK    = ABS_VCM + longint'(M - 1) * longint'(AMP);

    // Reject parameter sets whose extreme level or filter coefficient is unrepresentable
    if (PEAK >= LIMIT) begin : g_bad_range
        $error("pam_tx_channel_model: |VCM| + (M-1)*AMP does not fit DATA_WIDTH");
    end
    if ((ALPHA < 1) || (ALPHA > (32'd1 << ALPHA_FRAC))) begin : g_bad_alpha
        $error("pam_tx_channel_model: ALPHA outside 1..2**ALPHA_FRAC");
    end

    logic signed [DATA_WIDTH-1:0] tx_p_q, tx_p_d;
    logic signed [DATA_WIDTH-1:0] tx_n_q, tx_n_d;
    logic signed [DATA_WIDTH-1:0] ch_p_q, ch_p_d;
    logic signed [DATA_WIDTH-1:0] ch_n_q, ch_n_d;
    logic signed [PW-1:0]         lvl_w;
    logic signed [PW-1:0]         drv_p_w;
    logic signed [PW-1:0]         drv_n_w;

    function automatic logic signed [PW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
        return {{(PW - DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    // One IIR step; a zero floored step is forced to +-1 so y lands exactly on x
    function automatic logic signed [DATA_WIDTH-1:0] iir_step(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] y
    );
        logic signed [PW-1:0] diff;
        logic signed [PW-1:0] step;
        diff = sext(x) - sext(y);
        step = (diff * ALPHA_W) >>> ALPHA_FRAC;
        if ((diff != '0) && (step == '0)) begin
            step = diff[PW-1] ? '1 : PW'(1);
        end
        return DATA_WIDTH'(sext(y) + step);
    endfunction

    always_comb begin
        lvl_w   = $signed(PW'({bus_if.sym_in, 1'b0})) - LMAX_W;
        drv_p_w = VCM_W + lvl_w * AMP_W;
        drv_n_w = VCM_W - lvl_w * AMP_W;
        tx_p_d  = tx_p_q;
        tx_n_d  = tx_n_q;
        if (bus_if.sym_valid) begin
            tx_p_d = DATA_WIDTH'(drv_p_w);
            tx_n_d = DATA_WIDTH'(drv_n_w);
        end
        ch_p_d = iir_step(tx_p_q, ch_p_q);
        ch_n_d = iir_step(tx_n_q, ch_n_q);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_p_q <= VCM_D;
            tx_n_q <= VCM_D;
            ch_p_q <= VCM_D;
            ch_n_q <= VCM_D;
        end else begin
            tx_p_q <= tx_p_d;
            tx_n_q <= tx_n_d;
            ch_p_q <= ch_p_d;
            ch_n_q <= ch_n_d;
        end
    end

    assign bus_if.tx_p    = tx_p_q;
    assign bus_if.tx_n    = tx_n_q;
    assign bus_if.ch_p    = ch_p_q;
    assign bus_if.ch_n    = ch_n_q;
    assign bus_if.ch_diff = ch_p_q - ch_n_q;
endmodule

// File: tb/tb_pam_tx_channel_model.sv
// Bench for pam_tx_channel_model: NRZ/IIR, NRZ bypass and PAM4 bypass instances against an integer model.
module tb_pam_tx_channel_model;
    logic clk;
    logic rstb;

    int checks   = 0;
    int failures = 0;

    // Per-instance model parameters: 0 = NRZ alpha 64, 1 = NRZ bypass, 2 = PAM4 bypass VCM 100
    int p_vcm[3]   = '{0, 0, 100};
    int p_alpha[3] = '{64, 256, 256};
    int p_m[3]     = '{2, 2, 4};

    int m_txp[3];
    int m_txn[3];
    int m_chp[3];
    int m_chn[3];
    int d_sym[3];
    bit d_val[3];
    bit rnd_en[3];

    int exp_pam_p[4] = '{-2900, -900, 1100, 3100};
    int exp_pam_n[4] = '{3100, 1100, -900, -2900};

    pam_tx_channel_model_if #(.SYM_BITWIDTH(1), .DATA_WIDTH(16)) if_nrz ();
    pam_tx_channel_model_if #(.SYM_BITWIDTH(1), .DATA_WIDTH(16)) if_byp ();
    pam_tx_channel_model_if #(.SYM_BITWIDTH(2), .DATA_WIDTH(16)) if_pam ();

    pam_tx_channel_model u_nrz (.clk(clk), .rstb(rstb), .bus_if(if_nrz));

    pam_tx_channel_model #(.ALPHA(256)) u_byp (.clk(clk), .rstb(rstb), .bus_if(if_byp));

    pam_tx_channel_model #(.SYM_BITWIDTH(2), .VCM(100), .ALPHA(256)) u_pam (
        .clk(clk), .rstb(rstb), .bus_if(if_pam)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference low-pass step: floored fraction of the gap, never stalling short of the target
    function automatic int iir_ref(input int x, input int y, input int alpha);
        int num;
        int s;
        num = (x - y) * alpha;
        s = num / 256;
        if ((num < 0) && ((num % 256) != 0)) s = s - 1;
        if ((x != y) && (s == 0)) s = (x > y) ? 1 : -1;
        return y + s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_txp[i] = p_vcm[i];
            m_txn[i] = p_vcm[i];
            m_chp[i] = p_vcm[i];
            m_chn[i] = p_vcm[i];
        end
    endtask

    task automatic drive();
        if_nrz.sym_in    = 1'(d_sym[0]);
        if_nrz.sym_valid = d_val[0];
        if_byp.sym_in    = 1'(d_sym[1]);
        if_byp.sym_valid = d_val[1];
        if_pam.sym_in    = 2'(d_sym[2]);
        if_pam.sym_valid = d_val[2];
    endtask

    task automatic cmp_dut(input string nm, input int i,
                           input logic signed [31:0] tp, input logic signed [31:0] tn,
                           input logic signed [31:0] cp, input logic signed [31:0] cn,
                           input logic signed [31:0] cd);
        chk($sformatf("%s.tx_p", nm), tp, m_txp[i]);
        chk($sformatf("%s.tx_n", nm), tn, m_txn[i]);
        chk($sformatf("%s.ch_p", nm), cp, m_chp[i]);
        chk($sformatf("%s.ch_n", nm), cn, m_chn[i]);
        chk($sformatf("%s.ch_diff", nm), cd, m_chp[i] - m_chn[i]);
    endtask

    task automatic cmp_all();
        cmp_dut("nrz", 0, if_nrz.tx_p, if_nrz.tx_n, if_nrz.ch_p, if_nrz.ch_n, if_nrz.ch_diff);
        cmp_dut("byp", 1, if_byp.tx_p, if_byp.tx_n, if_byp.ch_p, if_byp.ch_n, if_byp.ch_diff);
        cmp_dut("pam", 2, if_pam.tx_p, if_pam.tx_n, if_pam.ch_p, if_pam.ch_n, if_pam.ch_diff);
    endtask

    // One UI: advance the model on the edge, compare after it, then pick new random inputs
    task automatic cycle();
        int lv;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rstb) begin
                m_txp[i] = p_vcm[i];
                m_txn[i] = p_vcm[i];
                m_chp[i] = p_vcm[i];
                m_chn[i] = p_vcm[i];
            end else begin
                m_chp[i] = iir_ref(m_txp[i], m_chp[i], p_alpha[i]);
                m_chn[i] = iir_ref(m_txn[i], m_chn[i], p_alpha[i]);
                if (d_val[i]) begin
                    lv = 2 * d_sym[i] - (p_m[i] - 1);
                    m_txp[i] = p_vcm[i] + lv * 1000;
                    m_txn[i] = p_vcm[i] - lv * 1000;
                end
            end
        end
        #1;
        cmp_all();
        for (int i = 0; i < 3; i++) begin
            if (rnd_en[i]) begin
                d_sym[i] = int'($urandom_range(p_m[i] - 1, 0));
                d_val[i] = ($urandom_range(3, 0) != 0);
            end
        end
        drive();
    endtask

    initial begin
        int n;
        int dv;
        int prev;
        bit crossed;

        rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_sym[i]  = 0;
            d_val[i]  = 1'b0;
            rnd_en[i] = 1'b0;
        end
        drive();

        // Asynchronous reset between edges
        #3 rstb = 1'b0;
        #1;
        model_reset();
        cmp_all();
        chk("rst_nrz_ch_diff", if_nrz.ch_diff, 0);
        #3 rstb = 1'b1;

        // Idle: no valid symbols, everything holds at common mode
        for (int k = 0; k < 10; k++) cycle();
        chk("idle_nrz_ch_p", if_nrz.ch_p, 0);
        chk("idle_pam_tx_p", if_pam.tx_p, 100);

        // NRZ step response
        rnd_en[1] = 1'b1;
        d_sym[0] = 1;
        d_val[0] = 1'b1;
        drive();
        cycle();
        chk("step_tx_p", if_nrz.tx_p, 1000);
        chk("step_tx_n", if_nrz.tx_n, -1000);
        cycle();
        chk("step_ch_p_e1", if_nrz.ch_p, 250);
        chk("step_ch_n_e1", if_nrz.ch_n, -250);
        cycle();
        chk("step_ch_p_e2", if_nrz.ch_p, 437);
        chk("step_ch_n_e2", if_nrz.ch_n, -438);
        cycle();
        chk("step_ch_p_e3", if_nrz.ch_p, 577);

        // Convergence to the exact level
        n = 0;
        while (!((int'(if_nrz.ch_p) == 1000) && (int'(if_nrz.ch_n) == -1000)) && (n < 40)) begin
            cycle();
            n++;
        end
        chk("conv_reached", ((int'(if_nrz.ch_p) == 1000) && (int'(if_nrz.ch_n) == -1000)) ? 1 : 0, 1);
        for (int k = 0; k < 5; k++) cycle();
        chk("conv_hold_ch_p", if_nrz.ch_p, 1000);
        chk("conv_hold_ch_n", if_nrz.ch_n, -1000);

        // Opposite transition: differential swings through zero to -2000
        d_sym[0] = 0;
        drive();
        crossed = 1'b0;
        prev = int'(if_nrz.ch_diff);
        n = 0;
        while ((int'(if_nrz.ch_diff) != -2000) && (n < 60)) begin
            cycle();
            dv = int'(if_nrz.ch_diff);
            if ((prev > 0) && (dv <= 0)) crossed = 1'b1;
            prev = dv;
            n++;
        end
        chk("toggle_crossed_zero", crossed, 1);
        chk("toggle_settled", if_nrz.ch_diff, -2000);
        for (int k = 0; k < 3; k++) cycle();
        chk("toggle_hold", if_nrz.ch_diff, -2000);

        // PAM4 level table and hold on invalid
        rnd_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_sym[2] = k;
            d_val[2] = 1'b1;
            drive();
            cycle();
            chk($sformatf("pam_tx_p_%0d", k), if_pam.tx_p, exp_pam_p[k]);
            chk($sformatf("pam_tx_n_%0d", k), if_pam.tx_n, exp_pam_n[k]);
        end
        d_sym[2] = 1;
        d_val[2] = 1'b0;
        drive();
        cycle();
        chk("pam_hold_tx_p", if_pam.tx_p, 3100);
        chk("pam_hold_tx_n", if_pam.tx_n, -2900);
        chk("pam_bypass_ch_p", if_pam.ch_p, 3100);

        // Reset in the middle of a ramp, then the ramp restarts from zero
        rnd_en[0] = 1'b0;
        d_sym[0] = 0;
        d_val[0] = 1'b0;
        drive();
        #2 rstb = 1'b0;
        #1;
        model_reset();
        cmp_all();
        #1 rstb = 1'b1;
        d_sym[0] = 1;
        d_val[0] = 1'b1;
        drive();
        cycle();
        cycle();
        cycle();
        chk("mid_pre_ch_p", if_nrz.ch_p, 437);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_ch_p", if_nrz.ch_p, 0);
        chk("mid_rst_tx_p", if_nrz.tx_p, 0);
        chk("mid_rst_ch_diff", if_nrz.ch_diff, 0);
        cmp_all();
        #1 rstb = 1'b1;
        cycle();
        chk("mid_re_tx_p", if_nrz.tx_p, 1000);
        cycle();
        chk("mid_re_ch_p_e1", if_nrz.ch_p, 250);
        cycle();
        chk("mid_re_ch_p_e2", if_nrz.ch_p, 437);

        // Random stream on every instance
        for (int i = 0; i < 3; i++) rnd_en[i] = 1'b1;
        for (int k = 0; k < 60; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
